// File: rtl/display_scan_arbiter.sv
// display_scan_arbiter: shares one 8-digit, 7-segment multiplexed display
// between two requesters. Frames are never cut short. The owner's data is
// latched into a shadow register only at frame boundaries, so a frame never
// shows a mix of old and new data.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero nibble. Digit 0 is never blanked.
//
// state  | meaning
// IDLE   | no owner, display dark
// SERVE0 | source 0 owns the display
// SERVE1 | source 1 owns the display
module display_scan_arbiter #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [1:0]  grant,
  output logic [7:0]  anodes,
  output logic [6:0]  segments
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2} state_t;

  state_t      state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [2:0]  digit, digit_nx;
  logic [7:0]  fcnt, fcnt_nx;
  logic [31:0] shadow, shadow_nx;
  logic        ptr, ptr_nx;
  logic [1:0]  grant_nx;
  logic [7:0]  anodes_nx;
  logic [6:0]  segments_nx;

  logic        tick;
  logic        owner;
  logic        other_req;
  logic        own_req;
  logic [8:0]  frames_done;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign tick        = (pre == PW'(SCAN_DIV - 1));
  assign owner       = (state == SERVE1);
  assign own_req     = owner ? req[1] : req[0];
  assign other_req   = owner ? req[0] : req[1];
  assign frames_done = {1'b0, fcnt} + 9'd1;

  // Next-state: arbitration, prescaler, digit scan and frame bookkeeping
  always_comb begin
    state_nx  = state;
    pre_nx    = pre;
    digit_nx  = digit;
    fcnt_nx   = fcnt;
    shadow_nx = shadow;
    ptr_nx    = ptr;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // on a tie, the source that did not own the display last time wins
          if (req == 2'b11) ptr_nx = ~ptr;
          else              ptr_nx = req[1];
          state_nx  = ptr_nx ? SERVE1 : SERVE0;
          shadow_nx = ptr_nx ? data1 : data0;
          pre_nx    = '0;
          digit_nx  = 3'd0;
          fcnt_nx   = 8'd0;
        end
      end
      SERVE0, SERVE1: begin
        if (!tick) begin
          pre_nx = pre + PW'(1);
        end else if (digit != 3'd7) begin
          pre_nx   = '0;
          digit_nx = digit + 3'd1;
        end else begin
          pre_nx   = '0;
          digit_nx = 3'd0;
          if (!own_req && !other_req) begin
            state_nx = IDLE;
            fcnt_nx  = 8'd0;
          end else if (other_req &&
                       (!own_req || frames_done >= 9'(HOLD_FRAMES))) begin
            state_nx  = owner ? SERVE0 : SERVE1;
            ptr_nx    = ~owner;
            shadow_nx = owner ? data0 : data1;
            fcnt_nx   = 8'd0;
          end else begin
            shadow_nx = owner ? data1 : data0;
            fcnt_nx   = (fcnt == 8'hFF) ? fcnt : fcnt + 8'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] msn;

  // Index of the highest nonzero nibble of the shadow being displayed next
  always_comb begin
    msn = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (shadow_nx[4*k +: 4] != 4'd0) msn = 3'(k);
    end
  end
`endif

  // Output decode from next-state values so outputs move with the digit index
  always_comb begin
    grant_nx    = 2'b00;
    anodes_nx   = 8'hFF;
    segments_nx = 7'h7F;
    if (state_nx != IDLE) begin
      grant_nx    = (state_nx == SERVE1) ? 2'b10 : 2'b01;
      anodes_nx   = ~(8'd1 << digit_nx);
      segments_nx = hex_to_seg(shadow_nx[{digit_nx, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (digit_nx > msn) begin
        anodes_nx   = 8'hFF;
        segments_nx = 7'h7F;
      end
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pre      <= '0;
      digit    <= 3'd0;
      fcnt     <= 8'd0;
      shadow   <= 32'd0;
      ptr      <= 1'b1;
      grant    <= 2'b00;
      anodes   <= 8'hFF;
      segments <= 7'h7F;
    end else begin
      state    <= state_nx;
      pre      <= pre_nx;
      digit    <= digit_nx;
      fcnt     <= fcnt_nx;
      shadow   <= shadow_nx;
      ptr      <= ptr_nx;
      grant    <= grant_nx;
      anodes   <= anodes_nx;
      segments <= segments_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Directed bench for display_scan_arbiter with SCAN_DIV=4, HOLD_FRAMES=2.
module tb_display_scan_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [1:0]  grant;
  logic [7:0]  anodes;
  logic [6:0]  segments;

  int passed = 0;
  int total  = 0;

  // expected display for data 32'h0001E240, digits 0..7
  logic [7:0] exp_an  [8];
  logic [6:0] exp_seg [8];

  display_scan_arbiter #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .grant    (grant),
    .anodes   (anodes),
    .segments (segments)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 2'b11;
    data0 = 32'h0;
    data1 = 32'h0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant);
      else passed++;
      total++;
      if (anodes !== 8'hFF) $display("FAIL reset_anodes got %h want ff", anodes);
      else passed++;
      total++;
      if (segments !== 7'h7F) $display("FAIL reset_segments got %h want 7f", segments);
      else passed++;
    end
    req   = 2'b00;
    reset = 1'b0;
    step();
    total++;
    if (grant !== 2'b00) $display("FAIL idle_grant got %b want 00", grant);
    else passed++;
  endtask

  task automatic test_scan();
    data0 = 32'h0001E240;
    req   = 2'b01;
    step();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k != 0 || c != 0) step();
        total++;
        if (grant !== 2'b01) $display("FAIL scan_grant d%0d c%0d got %b want 01", k, c, grant);
        else passed++;
        total++;
        if (anodes !== exp_an[k]) $display("FAIL scan_anodes d%0d c%0d got %h want %h", k, c, anodes, exp_an[k]);
        else passed++;
        total++;
        if (segments !== exp_seg[k]) $display("FAIL scan_segments d%0d c%0d got %b want %b", k, c, segments, exp_seg[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_drop_midframe();
    // continue: next frame with same owner, drop req at digit 3
    step();
    for (int i = 0; i < 12; i++) step();
    req = 2'b00;
    for (int k = 3; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k != 3 || c != 0) step();
        total++;
        if (grant !== 2'b01) $display("FAIL drop_grant d%0d c%0d got %b want 01", k, c, grant);
        else passed++;
        total++;
        if (anodes !== exp_an[k]) $display("FAIL drop_anodes d%0d c%0d got %h want %h", k, c, anodes, exp_an[k]);
        else passed++;
      end
    end
    step();
    total++;
    if (grant !== 2'b00) $display("FAIL drop_idle_grant got %b want 00", grant);
    else passed++;
    total++;
    if (anodes !== 8'hFF) $display("FAIL drop_idle_anodes got %h want ff", anodes);
    else passed++;
    total++;
    if (segments !== 7'h7F) $display("FAIL drop_idle_segments got %h want 7f", segments);
    else passed++;
  endtask

  task automatic test_no_tearing();
    data0 = 32'h11111111;
    req   = 2'b01;
    step();
    for (int i = 0; i < 8; i++) step();
    data0 = 32'h22222222;
    for (int k = 2; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k != 2 || c != 0) step();
        total++;
        if (segments !== 7'b1111001) $display("FAIL tear_old d%0d c%0d got %b want 1111001", k, c, segments);
        else passed++;
      end
    end
    step();
    total++;
    if (segments !== 7'b0100100) $display("FAIL tear_new got %b want 0100100", segments);
    else passed++;
    total++;
    if (anodes !== 8'hFE) $display("FAIL tear_new_anodes got %h want fe", anodes);
    else passed++;
    req = 2'b00;
    for (int i = 0; i < 32; i++) step();
    total++;
    if (grant !== 2'b00) $display("FAIL tear_idle got %b want 00", grant);
    else passed++;
  endtask

  task automatic test_alternate();
    reset = 1'b1;
    step();
    reset = 1'b0;
    data0 = 32'h0001E240;
    data1 = 32'hFEDCBA98;
    req   = 2'b11;
    step();
    for (int i = 0; i < 64; i++) begin
      total++;
      if (grant !== 2'b01) $display("FAIL alt_owner0 cyc%0d got %b want 01", i, grant);
      else passed++;
      step();
    end
    total++;
    if (anodes !== 8'hFE) $display("FAIL alt_switch_anodes got %h want fe", anodes);
    else passed++;
    total++;
    if (segments !== 7'b0000000) $display("FAIL alt_switch_segments got %b want 0000000", segments);
    else passed++;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (grant !== 2'b10) $display("FAIL alt_owner1 cyc%0d got %b want 10", i, grant);
      else passed++;
      step();
    end
    total++;
    if (grant !== 2'b01) $display("FAIL alt_back0 got %b want 01", grant);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    req   = 2'b10;
    step();
    total++;
    if (grant !== 2'b00) $display("FAIL rstmid_grant got %b want 00", grant);
    else passed++;
    total++;
    if (anodes !== 8'hFF) $display("FAIL rstmid_anodes got %h want ff", anodes);
    else passed++;
    reset = 1'b0;
    step();
    total++;
    if (grant !== 2'b10) $display("FAIL rstmid_req1 got %b want 10", grant);
    else passed++;
    total++;
    if (segments !== 7'b0000000) $display("FAIL rstmid_seg got %b want 0000000", segments);
    else passed++;
    // owner 1 alone, then a tie: owner 1 must hold for 2 full frames
    req = 2'b11;
    for (int i = 0; i < 63; i++) step();
    total++;
    if (grant !== 2'b10) $display("FAIL hold1_end got %b want 10", grant);
    else passed++;
    step();
    total++;
    if (grant !== 2'b01) $display("FAIL hold1_switch got %b want 01", grant);
    else passed++;
  endtask

  initial begin
    exp_an[0] = 8'hFE; exp_seg[0] = 7'b1000000;
    exp_an[1] = 8'hFD; exp_seg[1] = 7'b0011001;
    exp_an[2] = 8'hFB; exp_seg[2] = 7'b0100100;
    exp_an[3] = 8'hF7; exp_seg[3] = 7'b0000110;
    exp_an[4] = 8'hEF; exp_seg[4] = 7'b1111001;
`ifdef LEADING_ZERO_BLANK_EN
    exp_an[5] = 8'hFF; exp_seg[5] = 7'h7F;
    exp_an[6] = 8'hFF; exp_seg[6] = 7'h7F;
    exp_an[7] = 8'hFF; exp_seg[7] = 7'h7F;
`else
    exp_an[5] = 8'hDF; exp_seg[5] = 7'b1000000;
    exp_an[6] = 8'hBF; exp_seg[6] = 7'b1000000;
    exp_an[7] = 8'h7F; exp_seg[7] = 7'b1000000;
`endif
    test_reset();
    test_scan();
    test_drop_midframe();
    test_no_tearing();
    test_alternate();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
